traffic_phase_sched: RTL and testbench

TRAFFIC_PHASE_SCHED -- requirements
Module: traffic_phase_sched

---
 rtl/traffic_phase_sched.sv | 120 ++++++++++++
 tb/tb_traffic_phase_sched.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_phase_sched.sv
// Two-way intersection phase scheduler: NS/EW green, yellow and all-red clearance
// driven by a tick time base, with demand latches that gate the hand-off from green.
module traffic_phase_sched #(
    parameter int NS_GREEN_T = 32,
    parameter int EW_GREEN_T = 16,
    parameter int YEL_T      = 4,
    parameter int ALLRED_T   = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       ns_detect,
    input  logic       ew_detect,
    output logic       ns_red,
    output logic       ns_yellow,
    output logic       ns_green,
    output logic       ew_red,
    output logic       ew_yellow,
    output logic       ew_green,
    output logic [2:0] phase,
    output logic [5:0] timer
);

    localparam logic [2:0] S_NS_G = 3'd0;
    localparam logic [2:0] S_NS_Y = 3'd1;
    localparam logic [2:0] S_AR_1 = 3'd2;
    localparam logic [2:0] S_EW_G = 3'd3;
    localparam logic [2:0] S_EW_Y = 3'd4;
    localparam logic [2:0] S_AR_2 = 3'd5;

    logic [2:0] r_state;
    logic [2:0] w_next_state;
    logic [5:0] r_timer;
    logic [5:0] w_next_timer;
    logic       r_ns_req;
    logic       r_ew_req;
    logic [2:0] r_ns_lamp;   // {red, yellow, green}
    logic [2:0] r_ew_lamp;
    logic [2:0] w_ns_lamp;
    logic [2:0] w_ew_lamp;
    logic       w_expire;

    function automatic logic [5:0] load_value(input logic [2:0] s);
        case (s)
            S_NS_G:         return 6'(NS_GREEN_T - 1);
            S_EW_G:         return 6'(EW_GREEN_T - 1);
            S_NS_Y, S_EW_Y: return 6'(YEL_T - 1);
            default:        return 6'(ALLRED_T - 1);
        endcase
    endfunction

    assign w_expire = tick && (r_timer == 6'd0);

    // State register: timer, demand latches and lamps all move with the state.
    always_ff @(posedge clk) begin
        // NOTE: reset is sampled on the clock edge, so it wins over every other update in that edge.
        if (!rst_n) begin
            r_state   <= S_AR_2;
            r_timer   <= 6'(ALLRED_T - 1);
            r_ns_req  <= 1'b0;
            r_ew_req  <= 1'b0;
            r_ns_lamp <= 3'b100;
            r_ew_lamp <= 3'b100;
        end else begin
            // NOTE: non-blocking updates so every register here sees the pre-edge values.
            r_state   <= w_next_state;
            r_timer   <= w_next_timer;
            r_ns_lamp <= w_ns_lamp;
            r_ew_lamp <= w_ew_lamp;
            // Entry clear has priority so a detect on the entry cycle is absorbed by the green.
            if (w_next_state == S_NS_G && r_state != S_NS_G)
                r_ns_req <= 1'b0;
            else if (ns_detect && r_state != S_NS_G)
                r_ns_req <= 1'b1;
            if (w_next_state == S_EW_G && r_state != S_EW_G)
                r_ew_req <= 1'b0;
            else if (ew_detect && r_state != S_EW_G)
                r_ew_req <= 1'b1;
        end
    end

    // Next-state and timer logic; green is only released when the other side has demand.
    always_comb begin
        // NOTE: defaults first keep every path assigned, so no latch is inferred.
        w_next_state = r_state;
        w_next_timer = r_timer;
        case (r_state)
            S_NS_G: if (w_expire && (r_ew_req || ew_detect)) w_next_state = S_NS_Y;
            S_NS_Y: if (w_expire) w_next_state = S_AR_1;
            S_AR_1: if (w_expire) w_next_state = S_EW_G;
            S_EW_G: if (w_expire && (r_ns_req || ns_detect)) w_next_state = S_EW_Y;
            S_EW_Y: if (w_expire) w_next_state = S_AR_2;
            S_AR_2: if (w_expire) w_next_state = S_NS_G;
            default: w_next_state = S_AR_2;
        endcase
        if (w_next_state != r_state)
            w_next_timer = load_value(w_next_state);
        else if (tick && r_timer != 6'd0)
            w_next_timer = r_timer - 6'd1;
    end

    // Lamp decode from the next state so registered lamps line up with phase.
    always_comb begin
        w_ns_lamp = 3'b100;
        w_ew_lamp = 3'b100;
        case (w_next_state)
            S_NS_G:  w_ns_lamp = 3'b001;
            S_NS_Y:  w_ns_lamp = 3'b010;
            S_EW_G:  w_ew_lamp = 3'b001;
            S_EW_Y:  w_ew_lamp = 3'b010;
            default: ;
        endcase
    end

    assign {ns_red, ns_yellow, ns_green} = r_ns_lamp;
    assign {ew_red, ew_yellow, ew_green} = r_ew_lamp;
    assign phase = r_state;
    assign timer = r_timer;

endmodule

// File: tb/tb_traffic_phase_sched.sv
// Directed bench for traffic_phase_sched at default timing: reset, fixed period,
// green hold and demand latching, slow tick, mid-phase reset, illegal state, random run.
module tb_traffic_phase_sched;

    localparam int NS_G_T = 32;
    localparam int EW_G_T = 16;
    localparam int Y_T    = 4;
    localparam int AR_T   = 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick = 1'b0;
    logic       ns_detect = 1'b0;
    logic       ew_detect = 1'b0;
    logic       ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green;
    logic [2:0] phase;
    logic [5:0] timer;
    logic [5:0] lamps;

    int n_cmp = 0;
    int n_mis = 0;
    int inv_prints = 0;
    bit inv_en = 1'b0;

    traffic_phase_sched dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .tick      (tick),
        .ns_detect (ns_detect),
        .ew_detect (ew_detect),
        .ns_red    (ns_red),
        .ns_yellow (ns_yellow),
        .ns_green  (ns_green),
        .ew_red    (ew_red),
        .ew_yellow (ew_yellow),
        .ew_green  (ew_green),
        .phase     (phase),
        .timer     (timer)
    );

    always #5 clk = ~clk;

    assign lamps = {ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green};

    // Expected lamp pattern {ns r,y,g, ew r,y,g} for a phase.
    function automatic logic [5:0] lamp_of(input logic [2:0] p);
        case (p)
            3'd0:    return 6'b001_100;
            3'd1:    return 6'b010_100;
            3'd3:    return 6'b100_001;
            3'd4:    return 6'b100_010;
            default: return 6'b100_100;
        endcase
    endfunction

    // Safety invariant sampled on the falling edge of every cycle.
    always @(negedge clk) begin
        if (inv_en) begin
            n_cmp++;
            if (!($onehot({ns_red, ns_yellow, ns_green}) && $onehot({ew_red, ew_yellow, ew_green})
                  && (ns_red || ew_red))) begin
                n_mis++;
                if (inv_prints < 5)
                    $display("FAIL safety_invariant: lamps=%b at t=%0t", lamps, $time);
                inv_prints++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        tick = 1'b1; ns_detect = 1'b1; ew_detect = 1'b1;
        rst_n = 1'b0;
        step();
        inv_en = 1'b1;
        n_cmp++;
        if ({phase, timer, lamps} !== {3'd5, 6'(AR_T - 1), 6'b100_100}) begin
            n_mis++;
            $display("FAIL reset_state: got ph=%0d tm=%0d lamps=%b want ph=5 tm=%0d lamps=100100",
                     phase, timer, lamps, AR_T - 1);
        end
        step();
        n_cmp++;
        if ({dut.r_ns_req, dut.r_ew_req} !== 2'b00) begin
            n_mis++;
            $display("FAIL reset_latches: got %b want 00", {dut.r_ns_req, dut.r_ew_req});
        end
    endtask

    task automatic test_period();
        int seg_len[6];
        int p;
        int off;
        logic [5:0] exp_t;
        seg_len = '{NS_G_T, Y_T, AR_T, EW_G_T, Y_T, AR_T};
        tick = 1'b1; ns_detect = 1'b1; ew_detect = 1'b1;
        do_reset();
        p = 0;
        off = 0;
        for (int c = 0; c < 58; c++) begin
            step();
            exp_t = 6'(seg_len[p] - 1 - off);
            n_cmp++;
            if ({phase, timer, lamps} !== {3'(p), exp_t, lamp_of(3'(p))}) begin
                n_mis++;
                $display("FAIL period_c%0d: got ph=%0d tm=%0d lamps=%b want ph=%0d tm=%0d lamps=%b",
                         c + 1, phase, timer, lamps, p, exp_t, lamp_of(3'(p)));
            end
            off++;
            if (off == seg_len[p]) begin
                off = 0;
                p = (p + 1) % 6;
            end
        end
        step();
        n_cmp++;
        if ({phase, timer} !== {3'd0, 6'(NS_G_T - 1)}) begin
            n_mis++;
            $display("FAIL period_wrap: got ph=%0d tm=%0d want ph=0 tm=%0d", phase, timer, NS_G_T - 1);
        end
    endtask

    task automatic test_hold();
        tick = 1'b1; ns_detect = 1'b1; ew_detect = 1'b0;
        do_reset();
        step();
        n_cmp++;
        if ({phase, timer, dut.r_ns_req} !== {3'd0, 6'(NS_G_T - 1), 1'b0}) begin
            n_mis++;
            $display("FAIL hold_entry: got ph=%0d tm=%0d ns_req=%b want ph=0 tm=%0d ns_req=0",
                     phase, timer, dut.r_ns_req, NS_G_T - 1);
        end
        repeat (NS_G_T - 1 + 20) step();
        n_cmp++;
        if ({phase, timer, lamps} !== {3'd0, 6'd0, 6'b001_100}) begin
            n_mis++;
            $display("FAIL ns_hold: got ph=%0d tm=%0d lamps=%b want ph=0 tm=0 lamps=001100",
                     phase, timer, lamps);
        end
        ew_detect = 1'b1; ns_detect = 1'b0;
        step();
        ew_detect = 1'b0;
        n_cmp++;
        if ({phase, timer, lamps} !== {3'd1, 6'(Y_T - 1), 6'b010_100}) begin
            n_mis++;
            $display("FAIL ns_release: got ph=%0d tm=%0d lamps=%b want ph=1 tm=%0d lamps=010100",
                     phase, timer, lamps, Y_T - 1);
        end
        repeat (Y_T + AR_T + EW_G_T - 1 + 10) step();
        n_cmp++;
        if ({phase, timer, lamps} !== {3'd3, 6'd0, 6'b100_001}) begin
            n_mis++;
            $display("FAIL ew_hold: got ph=%0d tm=%0d lamps=%b want ph=3 tm=0 lamps=100001",
                     phase, timer, lamps);
        end
        // Demand pulse without a tick must be remembered until the next tick.
        tick = 1'b0; ns_detect = 1'b1;
        step();
        ns_detect = 1'b0;
        repeat (3) step();
        n_cmp++;
        if ({phase, timer} !== {3'd3, 6'd0}) begin
            n_mis++;
            $display("FAIL ew_wait_tick: got ph=%0d tm=%0d want ph=3 tm=0", phase, timer);
        end
        tick = 1'b1;
        step();
        n_cmp++;
        if ({phase, timer, lamps} !== {3'd4, 6'(Y_T - 1), 6'b100_010}) begin
            n_mis++;
            $display("FAIL ew_latched_release: got ph=%0d tm=%0d lamps=%b want ph=4 tm=%0d lamps=100010",
                     phase, timer, lamps, Y_T - 1);
        end
    endtask

    task automatic test_slow_tick();
        int k;
        tick = 1'b0; ns_detect = 1'b1; ew_detect = 1'b1;
        do_reset();
        k = 0;
        for (int c = 0; c < 40; c++) begin
            tick = (c % 4 == 0);
            step();
            if (tick) k++;
            n_cmp++;
            if ({phase, timer} !== {3'd0, 6'(NS_G_T - k)}) begin
                n_mis++;
                $display("FAIL slow_tick_c%0d: got ph=%0d tm=%0d want ph=0 tm=%0d",
                         c, phase, timer, NS_G_T - k);
            end
        end
        tick = 1'b1;
    endtask

    task automatic test_reset_mid();
        bit found;
        tick = 1'b1; ns_detect = 1'b1; ew_detect = 1'b1;
        do_reset();
        found = 1'b0;
        for (int c = 0; c < 200 && !found; c++) begin
            step();
            if (phase == 3'd3 && timer == 6'd9) found = 1'b1;
        end
        n_cmp++;
        if (!found) begin
            n_mis++;
            $display("FAIL reset_mid_reach: got ph=%0d tm=%0d want ph=3 tm=9 within 200 cycles",
                     phase, timer);
        end
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        n_cmp++;
        if ({phase, timer, lamps, dut.r_ns_req, dut.r_ew_req} !==
            {3'd5, 6'(AR_T - 1), 6'b100_100, 2'b00}) begin
            n_mis++;
            $display("FAIL reset_mid: got ph=%0d tm=%0d lamps=%b req=%b%b want ph=5 tm=%0d lamps=100100 req=00",
                     phase, timer, lamps, dut.r_ns_req, dut.r_ew_req, AR_T - 1);
        end
        step();
        n_cmp++;
        if ({phase, timer} !== {3'd0, 6'(NS_G_T - 1)}) begin
            n_mis++;
            $display("FAIL reset_first_phase: got ph=%0d tm=%0d want ph=0 tm=%0d",
                     phase, timer, NS_G_T - 1);
        end
    endtask

    task automatic test_illegal();
        tick = 1'b0;
        @(negedge clk);
        force dut.r_state = 3'd7;
        #1;
        release dut.r_state;
        step();
        n_cmp++;
        if ({phase, timer, lamps} !== {3'd5, 6'(AR_T - 1), 6'b100_100}) begin
            n_mis++;
            $display("FAIL illegal_recover: got ph=%0d tm=%0d lamps=%b want ph=5 tm=%0d lamps=100100",
                     phase, timer, lamps, AR_T - 1);
        end
        tick = 1'b1;
    endtask

    task automatic test_random();
        logic [2:0] pp;
        logic [2:0] exp_p;
        int cnt;
        int dur;
        ns_detect = 1'b0; ew_detect = 1'b0; tick = 1'b1;
        do_reset();
        cnt = 0;
        for (int c = 0; c < 10000; c++) begin
            pp = phase;
            tick = ($urandom_range(0, 1) == 1);
            ns_detect = ($urandom_range(0, 15) == 0);
            ew_detect = ($urandom_range(0, 15) == 0);
            step();
            if (tick && pp != 3'd0 && pp != 3'd3) cnt++;
            if (phase != pp) begin
                exp_p = 3'((pp + 1) % 6);
                dur = (pp == 3'd1 || pp == 3'd4) ? Y_T : ((pp == 3'd2 || pp == 3'd5) ? AR_T : 0);
                n_cmp++;
                if (phase !== exp_p || (dur != 0 && cnt != dur)) begin
                    n_mis++;
                    $display("FAIL random_seq_c%0d: from %0d got ph=%0d ticks=%0d want ph=%0d ticks=%0d",
                             c, pp, phase, cnt, exp_p, dur);
                end
                cnt = 0;
            end
        end
    endtask

    initial begin
        test_reset();
        test_period();
        test_hold();
        test_slow_tick();
        test_reset_mid();
        test_illegal();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
